// File: rtl/oldland_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : oldland_memory_if
// Data-bus bundle between the oldland memory stage (master) and memory (slave).
// Revision : 1.0
// ============================================================================
interface oldland_memory_if;
    logic [31:0] d_addr;
    logic [3:0]  d_bytesel;
    logic [31:0] d_wr_val;
    logic        d_wr_en;
    logic        d_access;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;

    modport master (
        output d_addr, d_bytesel, d_wr_val, d_wr_en, d_access,
        input  d_data, d_ack, d_error
    );

    modport slave (
        input  d_addr, d_bytesel, d_wr_val, d_wr_en, d_access,
        output d_data, d_ack, d_error
    );
endinterface
`default_nettype wire

// File: rtl/oldland_memory.sv
`default_nettype none
// ============================================================================
// Module   : oldland_memory
// Memory stage: one bus transaction per load/store, lane alignment, aborts.
// Revision : 1.0
// ============================================================================
module oldland_memory #(
    parameter int BUS_TIMEOUT = 256
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              load_i,
    input  wire              store_i,
    input  wire  [1:0]       width_i,
    input  wire  [31:0]      addr_i,
    input  wire  [31:0]      wdata_i,
    input  wire  [31:0]      wr_val_i,
    input  wire              update_rd_i,
    input  wire  [3:0]       rd_sel_i,
    input  wire              i_valid_i,
    output logic             busy_o,
    oldland_memory_if.master bus,
    output logic [31:0]      reg_wr_val_o,
    output logic             update_rd_out_o,
    output logic [3:0]       rd_sel_out_o,
    output logic             i_valid_out_o,
    output logic             data_abort_o,
    output logic [31:0]      fault_addr_o
);
    localparam int               CW      = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam bit               TO_EN   = (BUS_TIMEOUT > 0);
    localparam logic [CW-1:0]    TO_LAST = CW'(BUS_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] d_addr_q, d_addr_d;
    logic [3:0]  d_bytesel_q, d_bytesel_d;
    logic [31:0] d_wr_val_q, d_wr_val_d;
    logic        d_wr_en_q, d_wr_en_d;
    logic        d_access_q, d_access_d;

    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  width_q, width_d;
    logic        store_q, store_d;
    logic        upd_q, upd_d;
    logic [3:0]  rd_q, rd_d;

    logic [31:0] reg_wr_val_q, reg_wr_val_d;
    logic        update_rd_out_q, update_rd_out_d;
    logic [3:0]  rd_sel_out_q, rd_sel_out_d;
    logic        i_valid_out_q, i_valid_out_d;
    logic        data_abort_q, data_abort_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        w_mem, w_aligned, w_req, w_misalign, w_timeout;
    logic [3:0]  w_bytesel;
    logic [31:0] w_wr_val, w_shift_b, w_shift_h, w_load_data;

    assign w_mem      = load_i | store_i;
    assign w_req      = (state_q == ST_IDLE) & i_valid_i & w_mem & w_aligned;
    assign w_misalign = (state_q == ST_IDLE) & i_valid_i & w_mem & ~w_aligned;
    assign w_timeout  = TO_EN & (cnt_q == TO_LAST);
    assign w_shift_b  = bus.d_data >> {req_addr_q[1:0], 3'b000};
    assign w_shift_h  = bus.d_data >> {req_addr_q[1], 4'b0000};

    always_comb begin
        w_aligned = 1'b0;
        w_bytesel = 4'b1111;
        w_wr_val  = wdata_i;
        unique case (width_i)
            2'b00: begin
                w_aligned = 1'b1;
                w_bytesel = 4'b0001 << addr_i[1:0];
                w_wr_val  = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_aligned = ~addr_i[0];
                w_bytesel = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wr_val  = {2{wdata_i[15:0]}};
            end
            2'b10:   w_aligned = (addr_i[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    always_comb begin
        unique case (width_q)
            2'b00:   w_load_data = {24'h0, w_shift_b[7:0]};
            2'b01:   w_load_data = {16'h0, w_shift_h[15:0]};
            default: w_load_data = bus.d_data;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        busy_o          = 1'b0;
        cnt_d           = cnt_q;
        d_addr_d        = d_addr_q;
        d_bytesel_d     = d_bytesel_q;
        d_wr_val_d      = d_wr_val_q;
        d_wr_en_d       = d_wr_en_q;
        d_access_d      = d_access_q;
        req_addr_d      = req_addr_q;
        width_d         = width_q;
        store_d         = store_q;
        upd_d           = upd_q;
        rd_d            = rd_q;
        reg_wr_val_d    = reg_wr_val_q;
        update_rd_out_d = 1'b0;
        rd_sel_out_d    = rd_sel_out_q;
        i_valid_out_d   = 1'b0;
        data_abort_d    = 1'b0;
        fault_addr_d    = fault_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    busy_o      = 1'b1;
                    state_d     = ST_ACCESS;
                    cnt_d       = '0;
                    d_addr_d    = {addr_i[31:2], 2'b00};
                    d_bytesel_d = w_bytesel;
                    d_wr_val_d  = w_wr_val;
                    d_wr_en_d   = store_i;
                    d_access_d  = 1'b1;
                    req_addr_d  = addr_i;
                    width_d     = width_i;
                    store_d     = store_i;
                    upd_d       = update_rd_i;
                    rd_d        = rd_sel_i;
                end else if (w_misalign) begin
                    data_abort_d = 1'b1;
                    fault_addr_d = addr_i;
                end else if (!w_mem) begin
                    reg_wr_val_d    = wr_val_i;
                    update_rd_out_d = update_rd_i;
                    rd_sel_out_d    = rd_sel_i;
                    i_valid_out_d   = i_valid_i;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Error beats ack; a late ack still beats the timeout.
                if (bus.d_error || (w_timeout && !bus.d_ack)) begin
                    state_d      = ST_IDLE;
                    d_access_d   = 1'b0;
                    d_wr_en_d    = 1'b0;
                    data_abort_d = 1'b1;
                    fault_addr_d = req_addr_q;
                end else if (bus.d_ack) begin
                    state_d       = ST_IDLE;
                    d_access_d    = 1'b0;
                    d_wr_en_d     = 1'b0;
                    i_valid_out_d = 1'b1;
                    if (!store_q) begin
                        reg_wr_val_d    = w_load_data;
                        update_rd_out_d = upd_q;
                        rd_sel_out_d    = rd_q;
                    end
                end else begin
                    busy_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            d_addr_q        <= '0;
            d_bytesel_q     <= '0;
            d_wr_val_q      <= '0;
            d_wr_en_q       <= 1'b0;
            d_access_q      <= 1'b0;
            req_addr_q      <= '0;
            width_q         <= '0;
            store_q         <= 1'b0;
            upd_q           <= 1'b0;
            rd_q            <= '0;
            reg_wr_val_q    <= '0;
            update_rd_out_q <= 1'b0;
            rd_sel_out_q    <= '0;
            i_valid_out_q   <= 1'b0;
            data_abort_q    <= 1'b0;
            fault_addr_q    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            d_addr_q        <= d_addr_d;
            d_bytesel_q     <= d_bytesel_d;
            d_wr_val_q      <= d_wr_val_d;
            d_wr_en_q       <= d_wr_en_d;
            d_access_q      <= d_access_d;
            req_addr_q      <= req_addr_d;
            width_q         <= width_d;
            store_q         <= store_d;
            upd_q           <= upd_d;
            rd_q            <= rd_d;
            reg_wr_val_q    <= reg_wr_val_d;
            update_rd_out_q <= update_rd_out_d;
            rd_sel_out_q    <= rd_sel_out_d;
            i_valid_out_q   <= i_valid_out_d;
            data_abort_q    <= data_abort_d;
            fault_addr_q    <= fault_addr_d;
        end
    end

    assign bus.d_addr      = d_addr_q;
    assign bus.d_bytesel   = d_bytesel_q;
    assign bus.d_wr_val    = d_wr_val_q;
    assign bus.d_wr_en     = d_wr_en_q;
    assign bus.d_access    = d_access_q;
    assign reg_wr_val_o    = reg_wr_val_q;
    assign update_rd_out_o = update_rd_out_q;
    assign rd_sel_out_o    = rd_sel_out_q;
    assign i_valid_out_o   = i_valid_out_q;
    assign data_abort_o    = data_abort_q;
    assign fault_addr_o    = fault_addr_q;
endmodule
`default_nettype wire
